// File: rtl/ram_mar_pkg.sv
// Shared constants and state encoding for the RAM/MAR block of the bus computer.
package ram_mar_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/ram_mar_mar_reg.sv
// Memory address register: load from the bus, or post-increment with natural wrap.
module mar_reg #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          ld,
  input  logic          inc,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] q
);

  logic [AW-1:0] q_d;
  logic [AW-1:0] q_q;

  // Load beats increment; the AW-bit adder gives the DEPTH-1 -> 0 wrap for free.
  always_comb begin
    q_d = q_q;
    if (en) begin
      if (ld) begin
        q_d = d;
      end else if (inc) begin
        q_d = q_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ram_mar.sv
// Bus-attached RAM with its own address register; zeroes itself after every reset
// before it accepts requests.
module ram_mar
  import ram_mar_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  inout  wire [WIDTH-1:0] bus,
  input  logic          cs,
  input  logic          oa,
  input  logic          wa,
  input  logic          la,
  input  logic          inc,
  output logic [AW-1:0] mar_q,
  output logic          busy
);

  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             idle_sel;
  logic             rd_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [AW-1:0]    mar;

  // clr is folded in so a request in the reset cycle can never act.
  assign idle_sel = (state_q == IDLE) && cs && !clr;
  assign rd_en    = idle_sel && oa && !wa;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      IDLE:    ;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Single write port shared between the power-on sweep and bus writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = mar;
    mem_wdata = bus;
    if (state_q == CLEAR) begin
      mem_we    = !clr;
      mem_addr  = cnt_q;
      mem_wdata = '0;
    end else if (idle_sel && wa) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  mar_reg #(
    .AW(AW)
  ) u_mar (
    .clk (clk),
    .clr (clr),
    .en  (idle_sel),
    .ld  (la),
    .inc (inc),
    .d   (bus[AW-1:0]),
    .q   (mar)
  );

  assign bus   = rd_en ? mem[mar] : {WIDTH{1'bz}};
  assign mar_q = mar;
  assign busy  = busy_q;

endmodule

// File: tb/tb_ram_mar.sv
// Scoreboard bench for ram_mar: directed steps queue expected values, a monitor checks them.
module tb_ram_mar;

  localparam int W = 8;
  localparam int D = 16;
  localparam int K_BUS  = 0;
  localparam int K_MAR  = 1;
  localparam int K_BUSY = 2;
  // An undriven bus floats up to all ones through the pullups.
  localparam logic [W-1:0] BUS_Z = 8'hFF;

  typedef struct {
    int           due;
    int           kind;
    logic [W-1:0] val;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         cs = 1'b0, oa = 1'b0, wa = 1'b0, la = 1'b0, inc = 1'b0;
  logic         tb_drv = 1'b0;
  logic [W-1:0] tb_data = '0;
  wire  [W-1:0] bus;
  logic [3:0]   mar_q;
  logic         busy;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  assign bus = tb_drv ? tb_data : {W{1'bz}};

  for (genvar g = 0; g < W; g++) begin : g_pu
    pullup pu (bus[g]);
  end

  ram_mar #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .clr   (clr),
    .bus   (bus),
    .cs    (cs),
    .oa    (oa),
    .wa    (wa),
    .la    (la),
    .inc   (inc),
    .mar_q (mar_q),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Monitor: one sample per cycle, just after the rising edge.
  initial begin
    exp_t         e;
    logic [W-1:0] act;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        case (e.kind)
          K_BUS:   act = bus;
          K_MAR:   act = {4'b0, mar_q};
          default: act = {7'b0, busy};
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("[TB] FAIL %s (cycle %0d): got %h expected %h", e.name, cyc, act, e.val);
        end
      end
    end
  end

  task automatic applyStimulus(input logic c, input logic o, input logic w, input logic l,
                               input logic i, input logic drv, input logic [W-1:0] d);
    cs = c; oa = o; wa = w; la = l; inc = i;
    tb_drv = drv; tb_data = d;
  endtask

  task automatic step(input logic c, input logic o, input logic w, input logic l,
                      input logic i, input logic drv, input logic [W-1:0] d);
    @(negedge clk);
    applyStimulus(c, o, w, l, i, drv, d);
  endtask

  task automatic checkOutput(input int kind, input string name, input logic [W-1:0] val);
    exp_t e;
    e.due = cyc + 1; e.kind = kind; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  // Caller has just released clr at a falling edge; covers the 16 edges that follow.
  task automatic runSweep(input logic noisy);
    for (int i = 1; i <= D; i++) begin
      if (i > 1) @(negedge clk);
      if (noisy && i >= 3 && i <= 4) begin
        applyStimulus(1, 1, 0, 1, 1, 0, 8'h00);
        checkOutput(K_BUS, "bus_z_busy", BUS_Z);
        checkOutput(K_MAR, "mar_hold_busy", 8'd0);
      end else if (noisy && i >= 5 && i <= 6) begin
        applyStimulus(1, 1, 1, 1, 0, 1, 8'h77);
        checkOutput(K_MAR, "mar_hold_busy_wr", 8'd0);
      end else begin
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
      end
      checkOutput(K_BUSY, "busy_sweep", (i < D) ? 8'd1 : 8'd0);
    end
  endtask

  task automatic readAt(input logic [W-1:0] a, input logic [W-1:0] val, input string name);
    step(1, 0, 0, 1, 0, 1, a);
    step(1, 1, 0, 0, 0, 0, 8'h00);
    checkOutput(K_BUS, name, val);
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    checkOutput(K_BUSY, "busy_in_reset", 8'd1);
    checkOutput(K_MAR, "mar_in_reset", 8'd0);
    @(negedge clk);
    clr = 1'b0;
    runSweep(0);

    // Whole array reads zero; oa+inc walks through every address and wraps.
    for (int a = 0; a < D; a++) begin
      step(1, 1, 0, 0, 1, 0, 8'h00);
      checkOutput(K_BUS, "sweep_read_zero", 8'h00);
      checkOutput(K_MAR, "sweep_mar_walk", 8'((a + 1) % D));
    end

    // Load, write, read back, then confirm the bus floats.
    step(1, 0, 0, 1, 0, 1, 8'h03);  checkOutput(K_MAR, "la_03", 8'd3);
    step(1, 0, 1, 0, 0, 1, 8'hA5);  checkOutput(K_MAR, "mar_after_wr", 8'd3);
    step(1, 1, 0, 0, 0, 0, 8'h00);  checkOutput(K_BUS, "read_A5", 8'hA5);
    step(1, 0, 0, 0, 0, 0, 8'h00);  checkOutput(K_BUS, "bus_z_oa0", BUS_Z);
    step(0, 1, 0, 0, 0, 0, 8'h00);  checkOutput(K_BUS, "bus_z_cs0", BUS_Z);

    // Wrap and ignored upper address bits.
    step(1, 0, 0, 1, 0, 1, 8'h0F);  checkOutput(K_MAR, "la_0F", 8'd15);
    step(1, 0, 0, 0, 1, 0, 8'h00);  checkOutput(K_MAR, "inc_wrap", 8'd0);
    step(1, 0, 0, 1, 0, 1, 8'hF2);  checkOutput(K_MAR, "la_F2_upper_ignored", 8'd2);
    step(1, 0, 0, 1, 1, 1, 8'h05);  checkOutput(K_MAR, "la_beats_inc", 8'd5);
    step(0, 0, 0, 1, 1, 1, 8'h09);  checkOutput(K_MAR, "cs0_holds_mar", 8'd5);

    // Indirect addressing: mem[1] holds a pointer to 7.
    step(1, 0, 0, 1, 0, 1, 8'h01);
    step(1, 0, 1, 0, 0, 1, 8'h07);
    step(1, 0, 0, 1, 0, 1, 8'h07);
    step(1, 0, 1, 0, 0, 1, 8'h55);
    step(1, 0, 0, 1, 0, 1, 8'h01);  checkOutput(K_MAR, "la_01", 8'd1);
    step(1, 1, 0, 1, 0, 0, 8'h00);  checkOutput(K_MAR, "indirect_mar", 8'd7);
    step(1, 1, 0, 0, 0, 0, 8'h00);  checkOutput(K_BUS, "indirect_read", 8'h55);

    // Write with inc lands at the old address; oa+wa writes without driving.
    step(1, 0, 0, 1, 0, 1, 8'h02);
    step(1, 0, 1, 0, 1, 1, 8'h11);  checkOutput(K_MAR, "wr_inc_mar", 8'd3);
    readAt(8'h02, 8'h11, "wr_inc_old_addr");
    readAt(8'h03, 8'hA5, "neighbour_intact");
    step(1, 0, 0, 1, 0, 1, 8'h04);
    step(1, 1, 1, 0, 0, 1, 8'h3C);  checkOutput(K_BUS, "oa_wa_no_drive", 8'h3C);
    step(1, 1, 0, 0, 0, 0, 8'h00);  checkOutput(K_BUS, "oa_wa_written", 8'h3C);

    // Reset mid-sweep restarts the full sweep; requests during it are ignored.
    @(negedge clk);
    clr = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
    checkOutput(K_MAR, "mar_cleared_by_clr", 8'd0);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge clk);
      checkOutput(K_BUSY, "busy_partial", 8'd1);
    end
    @(negedge clk);
    clr = 1'b1;
    checkOutput(K_BUSY, "busy_restart", 8'd1);
    @(negedge clk);
    clr = 1'b0;
    runSweep(1);
    readAt(8'h00, 8'h00, "busy_write_ignored");
    readAt(8'h01, 8'h00, "resweep_zero_1");
    readAt(8'h02, 8'h00, "resweep_zero_2");
    readAt(8'h03, 8'h00, "resweep_zero_3");
    readAt(8'h07, 8'h00, "resweep_zero_7");
    step(0, 0, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_mar.md
RAM_MAR -- requirements
Module: ram_mar

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word and bus width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning word count; it SHALL be a power of two and at least 2.
REQ-003 SHALL have localparam AW = $clog2(DEPTH), meaning address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port clr, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port bus, inout, WIDTH bits: the shared tri-state system bus.
REQ-007 SHALL have port cs, input, 1 bit: chip select; it qualifies oa, wa, la and inc.
REQ-008 SHALL have port oa, input, 1 bit: output enable; the block drives mem[mar] onto bus.
REQ-009 SHALL have port wa, input, 1 bit: write enable; the block writes bus into mem[mar].
REQ-010 SHALL have port la, input, 1 bit: load the memory address register from bus[AW-1:0].
REQ-011 SHALL have port inc, input, 1 bit: post-increment the memory address register.
REQ-012 SHALL have port mar_q, output, AW bits: the current memory address register.
REQ-013 SHALL have port busy, output, 1 bit: the block is running its power-on clear and ignores all requests.

Function
REQ-014 SHALL have two states: CLEAR and IDLE.
REQ-015 In CLEAR, on each clock edge the block SHALL write 0 to mem[cnt], then increment cnt; after writing address DEPTH-1 it SHALL move to IDLE.
REQ-016 After clr deasserts, busy SHALL stay high for exactly DEPTH rising edges, then go low.
REQ-017 While busy=1, cs, oa, wa, la and inc SHALL be ignored; bus SHALL be high-Z; mar SHALL hold its value.
REQ-018 In IDLE, bus SHALL be driven combinationally with mem[mar] when cs=1, oa=1 and wa=0; otherwise bus SHALL be high-Z.
REQ-019 In IDLE, when cs=1 and wa=1, mem[mar] SHALL take the value on bus at the rising edge.
REQ-020 When cs=1, oa=1 and wa=1 together, the write SHALL take priority and the block SHALL NOT drive bus.
REQ-021 In IDLE, when cs=1 and la=1, mar SHALL take bus[AW-1:0] at the edge; the upper bus bits SHALL be ignored.
REQ-022 In IDLE, when cs=1, la=0 and inc=1, mar SHALL become (mar+1) mod DEPTH; DEPTH-1 wraps to 0.
REQ-023 If la and inc are both set, la SHALL win.
REQ-024 A write or read in the same cycle as la/inc SHALL use the pre-edge mar; the write lands at the old address.
REQ-025 With cs=1, oa=1 and la=1 together, mar SHALL load the block's own driven data (indirect addressing); this is legal.
REQ-026 mar_q SHALL equal mar at all times.

Reset
REQ-027 clr=1 SHALL immediately force: state=CLEAR, cnt=0, mar=0, busy=1, bus high-Z.
REQ-028 Memory contents SHALL NOT be reset asynchronously; they SHALL be zeroed only by the CLEAR sweep.
REQ-029 clr asserted during the CLEAR sweep SHALL restart the sweep from address 0.
REQ-030 clr asserted in IDLE SHALL discard any pending write; the cycle's write SHALL NOT occur.

Structure
REQ-031 The state encoding (CLEAR, IDLE) and default WIDTH/DEPTH constants SHALL live in the shared computer package.
REQ-032 The memory address register with load/increment/wrap SHALL be the sub-module mar_reg (params AW; ports clk, clr, en, ld, inc, d, q).
REQ-033 The storage array SHALL be a single reg array of DEPTH x WIDTH inside ram_mar.

Verification
REQ-034 Scenario: pulse clr with DEPTH=16 -> busy=1 for 16 edges, then 0; every address then reads 8'h00.
REQ-035 Scenario: la with bus=8'h03, then wa with bus=8'hA5, then oa -> mar_q=3 and bus=8'hA5; with oa=0, bus is Z.
REQ-036 Scenario: la 8'h0F, then inc -> mar_q=0; la 8'hF2 -> mar_q=2, upper bits ignored.
REQ-037 Scenario: mem[1]=8'h07, mem[7]=8'h55; la 1, then oa+la in one cycle -> mar_q=7; then oa -> bus=8'h55.
REQ-038 Scenario: write 8'h11 at address 2 while inc=1 -> mem[2]=8'h11, mar_q=3; oa+wa together -> write occurs and bus is not driven by the block.
REQ-039 Scenario: assert clr at cycle 5 of the sweep -> busy stays high for 16 more edges after release; wa/oa during busy have no effect.
